// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU operation
// codes, memory access size codes and the MUL/DIV sequencer states.
package ex_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int ALU_OP_W = 4;
  localparam int MD_ITERS = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10,
    ALU_BEQ = 4'd11,
    ALU_BNE = 4'd12,
    ALU_MUL = 4'd13,
    ALU_DIV = 4'd14
  } alu_op_e;

  // Memory access sizes carried through to the memory stage untouched.
  localparam logic [1:0] MEM_NONE     = 2'd0;
  localparam logic [1:0] MEM_WORD     = 2'd1;
  localparam logic [1:0] MEM_HALFWORD = 2'd2;
  localparam logic [1:0] MEM_BYTE     = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_mul_div(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage as one bundle.
// master = the pipeline side feeding ID/EX and consuming EX/MEM.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [DATA_W-1:0]   IDEX_pc_i;
  logic [DATA_W-1:0]   IDEX_a_i;
  logic [DATA_W-1:0]   IDEX_b_i;
  logic [DATA_W-1:0]   IDEX_imm_i;
  logic [REG_W-1:0]    IDEX_rt_i;
  logic [REG_W-1:0]    IDEX_rd_i;
  logic [ALU_OP_W-1:0] IDEX_ctrl_alu_op_i;
  logic                IDEX_ctrl_alu_src_i;
  logic                IDEX_ctrl_reg_dst_i;
  logic                IDEX_ctrl_branch_i;
  logic                IDEX_ctrl_reg_write_i;
  logic                IDEX_ctrl_mem_to_reg_i;
  logic [1:0]          IDEX_ctrl_mem_read_i;
  logic [1:0]          IDEX_ctrl_mem_write_i;

  logic [DATA_W-1:0]   EXMEM_pc_branched_o;
  logic [DATA_W-1:0]   EXMEM_alu_o;
  logic                EXMEM_alu_do_branch_o;
  logic [DATA_W-1:0]   EXMEM_b_o;
  logic [REG_W-1:0]    EXMEM_reg_write_address_o;
  logic                EXMEM_ctrl_branch_o;
  logic                EXMEM_ctrl_reg_write_o;
  logic                EXMEM_ctrl_mem_to_reg_o;
  logic [1:0]          EXMEM_ctrl_mem_read_o;
  logic [1:0]          EXMEM_ctrl_mem_write_o;

  modport master (
    output IDEX_pc_i, IDEX_a_i, IDEX_b_i, IDEX_imm_i, IDEX_rt_i, IDEX_rd_i,
           IDEX_ctrl_alu_op_i, IDEX_ctrl_alu_src_i, IDEX_ctrl_reg_dst_i,
           IDEX_ctrl_branch_i, IDEX_ctrl_reg_write_i, IDEX_ctrl_mem_to_reg_i,
           IDEX_ctrl_mem_read_i, IDEX_ctrl_mem_write_i,
    input  EXMEM_pc_branched_o, EXMEM_alu_o, EXMEM_alu_do_branch_o, EXMEM_b_o,
           EXMEM_reg_write_address_o, EXMEM_ctrl_branch_o, EXMEM_ctrl_reg_write_o,
           EXMEM_ctrl_mem_to_reg_o, EXMEM_ctrl_mem_read_o, EXMEM_ctrl_mem_write_o
  );

  modport slave (
    input  IDEX_pc_i, IDEX_a_i, IDEX_b_i, IDEX_imm_i, IDEX_rt_i, IDEX_rd_i,
           IDEX_ctrl_alu_op_i, IDEX_ctrl_alu_src_i, IDEX_ctrl_reg_dst_i,
           IDEX_ctrl_branch_i, IDEX_ctrl_reg_write_i, IDEX_ctrl_mem_to_reg_i,
           IDEX_ctrl_mem_read_i, IDEX_ctrl_mem_write_i,
    output EXMEM_pc_branched_o, EXMEM_alu_o, EXMEM_alu_do_branch_o, EXMEM_b_o,
           EXMEM_reg_write_address_o, EXMEM_ctrl_branch_o, EXMEM_ctrl_reg_write_o,
           EXMEM_ctrl_mem_to_reg_o, EXMEM_ctrl_mem_read_o, EXMEM_ctrl_mem_write_o
  );

endinterface

// File: rtl/ex_stage_mul_div_unit.sv
// Sequential unsigned multiply / divide: one bit per cycle over 32 cycles.
// MUL is shift-add (low word of the product), DIV is restoring division
// (quotient). A zero divisor never subtracts-fails, so the quotient comes
// out as all ones with the normal latency.
module mul_div_unit
  import ex_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              start_i,
  input  logic              div_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  md_state_e           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   opnd_q;
  logic                is_div_q;

  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_rem;
  logic                div_ge;
  logic [DATA_W-1:0]   div_sub;
  logic [2*DATA_W-1:0] div_next;

  // Multiply step: add multiplicand on the upper half when the LSB is set,
  // then shift the whole accumulator right, keeping the carry.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]}
                             : {1'b0, acc_q[2*DATA_W-1:1]};

  // Divide step: shift remainder:dividend left, subtract when it fits and
  // shift a quotient bit into the bottom.
  assign div_rem  = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_ge   = div_rem >= {1'b0, opnd_q};
  assign div_sub  = div_rem[DATA_W-1:0] - opnd_q;
  assign div_next = div_ge ? {div_sub, acc_q[DATA_W-2:0], 1'b1}
                           : {acc_q[2*DATA_W-2:0], 1'b0};

  // Sequencer: IDLE loads, BUSY iterates 32 times, DONE presents the result.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else if (flush_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          cnt_q <= '0;
          if (start_i) state_q <= MD_BUSY;
        end
        MD_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MD_ITERS - 1)) state_q <= MD_DONE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  // Operand capture and per-cycle iteration of the accumulator.
  always_ff @(posedge clk_i) begin
    if (state_q == MD_IDLE && start_i && !flush_i) begin
      acc_q    <= {{DATA_W{1'b0}}, a_i};
      opnd_q   <= b_i;
      is_div_q <= div_i;
    end else if (state_q == MD_BUSY) begin
      acc_q <= is_div_q ? div_next : mul_next;
    end
  end

  // Busy covers the loading IDLE cycle too: the result exists only in DONE.
  assign busy_o   = (state_q != MD_DONE);
  assign done_o   = (state_q == MD_DONE);
  assign result_o = acc_q[DATA_W-1:0];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand/destination muxes, ALU, branch target and
// condition, and the EX/MEM pipeline register. MUL/DIV go to the
// sequential unit and hold the upstream pipeline while it works.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic      clk_i,
  input  logic      n_rst_i,
  input  logic      EX_flush_i,
  output logic      EX_stall_o,
  ex_stage_if.slave bus
);

  function automatic logic signed [DATA_W-1:0] alu_f(
    input logic [ALU_OP_W-1:0]      op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (op)
      ALU_ADD:          r = a + b;
      ALU_SUB:          r = a - b;
      ALU_AND:          r = a & b;
      ALU_OR:           r = a | b;
      ALU_XOR:          r = a ^ b;
      ALU_NOR:          r = ~(a | b);
      ALU_SLT:          r = (a < b) ? DATA_W'(1) : '0;
      ALU_SLL:          r = a << b[4:0];
      ALU_SRL:          r = $signed($unsigned(a) >> b[4:0]);
      ALU_SRA:          r = a >>> b[4:0];
      ALU_LUI:          r = b << 16;
      ALU_BEQ, ALU_BNE: r = a - b;
      default:          r = '0;
    endcase
    return r;
  endfunction

  logic [ALU_OP_W-1:0]      op;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic signed [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0]        pc_br;
  logic                     do_br;
  logic [REG_W-1:0]         wa;
  logic                     is_md;
  logic                     md_busy;
  logic                     md_done;
  logic [DATA_W-1:0]        md_res;
  logic [DATA_W-1:0]        result;
  logic                     bubble;

  assign op      = bus.IDEX_ctrl_alu_op_i;
  assign op_a    = $signed(bus.IDEX_a_i);
  assign op_b    = bus.IDEX_ctrl_alu_src_i ? $signed(bus.IDEX_imm_i) : $signed(bus.IDEX_b_i);
  assign alu_res = alu_f(op, op_a, op_b);
  assign pc_br   = bus.IDEX_pc_i + {bus.IDEX_imm_i[DATA_W-3:0], 2'b00};
  assign do_br   = ((op == ALU_BEQ) && (op_a == op_b)) ||
                   ((op == ALU_BNE) && (op_a != op_b));
  assign wa      = bus.IDEX_ctrl_reg_dst_i ? bus.IDEX_rd_i : bus.IDEX_rt_i;
  assign is_md   = is_mul_div(op);

  mul_div_unit u_mul_div (
    .clk_i    (clk_i),
    .n_rst_i  (n_rst_i),
    .start_i  (is_md),
    .div_i    (op == ALU_DIV),
    .a_i      ($unsigned(op_a)),
    .b_i      ($unsigned(op_b)),
    .flush_i  (EX_flush_i),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  // DONE only follows BUSY with the same MUL/DIV held, so it selects the unit.
  assign result     = md_done ? md_res : $unsigned(alu_res);
  assign EX_stall_o = is_md & md_busy & ~EX_flush_i;
  assign bubble     = EX_stall_o | EX_flush_i;

  // ---- EX/MEM boundary ----
  logic [DATA_W-1:0] alu_p1;
  logic [DATA_W-1:0] pc_br_p1;
  logic              do_br_p1;
  logic [DATA_W-1:0] b_p1;
  logic [REG_W-1:0]  wa_p1;
  logic              branch_p1;
  logic              reg_write_p1;
  logic              mem_to_reg_p1;
  logic [1:0]        mem_read_p1;
  logic [1:0]        mem_write_p1;
  logic              vld_p1;

  // EX/MEM register; a stall or flush leaves vld_p1 low, which zeroes ctrl.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      vld_p1        <= 1'b0;
      alu_p1        <= '0;
      pc_br_p1      <= '0;
      do_br_p1      <= 1'b0;
      b_p1          <= '0;
      wa_p1         <= '0;
      branch_p1     <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_read_p1   <= '0;
      mem_write_p1  <= '0;
    end else begin
      vld_p1        <= ~bubble;
      alu_p1        <= result;
      pc_br_p1      <= pc_br;
      do_br_p1      <= do_br;
      b_p1          <= bus.IDEX_b_i;
      wa_p1         <= wa;
      branch_p1     <= bus.IDEX_ctrl_branch_i;
      reg_write_p1  <= bus.IDEX_ctrl_reg_write_i;
      mem_to_reg_p1 <= bus.IDEX_ctrl_mem_to_reg_i;
      mem_read_p1   <= bus.IDEX_ctrl_mem_read_i;
      mem_write_p1  <= bus.IDEX_ctrl_mem_write_i;
    end
  end

  assign bus.EXMEM_alu_o               = alu_p1;
  assign bus.EXMEM_pc_branched_o       = pc_br_p1;
  assign bus.EXMEM_alu_do_branch_o     = do_br_p1 & vld_p1;
  assign bus.EXMEM_b_o                 = b_p1;
  assign bus.EXMEM_reg_write_address_o = wa_p1;
  assign bus.EXMEM_ctrl_branch_o       = branch_p1 & vld_p1;
  assign bus.EXMEM_ctrl_reg_write_o    = reg_write_p1 & vld_p1;
  assign bus.EXMEM_ctrl_mem_to_reg_o   = mem_to_reg_p1 & vld_p1;
  assign bus.EXMEM_ctrl_mem_read_o     = mem_read_p1 & {2{vld_p1}};
  assign bus.EXMEM_ctrl_mem_write_o    = mem_write_p1 & {2{vld_p1}};

endmodule
